win_detect: RTL and testbench

- Downstream of game_logic; consumes the current game board after each flood move.
- Scans the active SIZE x SIZE region cell by cell in row-major order through a read-address interface.
- Counts the cells that match the origin cell (0,0) colour and reports whether the board is uniform (win).
- Result feeds select, which uses WIN to end the game and stop the TRIES count.

---
 rtl/win_detect.sv | 120 ++++++++++++
 tb/tb_win_detect.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/win_detect.sv
// Scans the active SIZE x SIZE board region in row-major order and reports whether every cell matches cell(0,0).
// Optional early exit on the first mismatch: define WIN_DETECT_EARLY_EXIT_EN.
module win_detect #(
    parameter int MAX_SIZE = 26,
    parameter int MIN_SIZE = 2,
    parameter int COLOR_W  = 3
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               START,
    input  logic [4:0]         SIZE,
    output logic [4:0]         ROW,
    output logic [4:0]         COL,
    input  logic [COLOR_W-1:0] CELL,
    output logic               BUSY,
    output logic               DONE,
    output logic               WIN,
    output logic [9:0]         FILL_COUNT,
    output logic [1:0]         STATE
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state;
    logic [4:0]         n;
    logic [COLOR_W-1:0] ref_color;
    logic [4:0]         size_clamped;
    logic [9:0]         area;
    logic               first;
    logic               last;
    logic               match;
    logic               stop_early;
    logic [9:0]         count_next;

    assign STATE = state;
    assign area  = {5'd0, n} * {5'd0, n};

    always_comb begin
        size_clamped = SIZE;
        if (SIZE < 5'(MIN_SIZE)) begin
            size_clamped = 5'(MIN_SIZE);
        end else if (SIZE > 5'(MAX_SIZE)) begin
            size_clamped = 5'(MAX_SIZE);
        end
    end

    // The origin is only ever addressed on the first scan cycle, so it doubles as the k=1 marker.
    assign first      = (ROW == 5'd0) && (COL == 5'd0);
    assign last       = (ROW == n - 5'd1) && (COL == n - 5'd1);
    assign match      = (CELL == ref_color);
    assign count_next = first ? 10'd1 : FILL_COUNT + {9'd0, match};

`ifdef WIN_DETECT_EARLY_EXIT_EN
    assign stop_early = !first && !match;
`else
    assign stop_early = 1'b0;
`endif

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state      <= IDLE;
            n          <= 5'd0;
            ref_color  <= '0;
            ROW        <= 5'd0;
            COL        <= 5'd0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            WIN        <= 1'b0;
            FILL_COUNT <= 10'd0;
        end else begin
            case (state)
                IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        n          <= size_clamped;
                        ROW        <= 5'd0;
                        COL        <= 5'd0;
                        FILL_COUNT <= 10'd0;
                        WIN        <= 1'b0;
                        BUSY       <= 1'b1;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    if (first) begin
                        ref_color <= CELL;
                    end
                    FILL_COUNT <= count_next;
                    if (stop_early) begin
                        state <= FINISH;
                        DONE  <= 1'b1;
                        WIN   <= 1'b0;
                    end else if (last) begin
                        state <= FINISH;
                        DONE  <= 1'b1;
                        WIN   <= (count_next == area);
                    end else if (COL == n - 5'd1) begin
                        COL <= 5'd0;
                        ROW <= ROW + 5'd1;
                    end else begin
                        COL <= COL + 5'd1;
                    end
                end
                FINISH: begin
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_win_detect.sv
// Directed bench for win_detect: a board array answers the ROW/COL read port combinationally.
module tb_win_detect;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic [4:0] SIZE  = 5'd0;
    logic [4:0] ROW;
    logic [4:0] COL;
    logic [2:0] CELL;
    logic       BUSY;
    logic       DONE;
    logic       WIN;
    logic [9:0] FILL_COUNT;
    logic [1:0] STATE;

    int checks   = 0;
    int failures = 0;

    logic [2:0] board [0:25][0:25];
    logic [4:0] addr_r [0:3];
    logic [4:0] addr_c [0:3];

    win_detect dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .START      (START),
        .SIZE       (SIZE),
        .ROW        (ROW),
        .COL        (COL),
        .CELL       (CELL),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .WIN        (WIN),
        .FILL_COUNT (FILL_COUNT),
        .STATE      (STATE)
    );

    always #5 CLOCK = ~CLOCK;

    assign CELL = board[ROW][COL];

    task automatic fill_board(input logic [2:0] c);
        for (int i = 0; i < 26; i++)
            for (int j = 0; j < 26; j++)
                board[i][j] = c;
    endtask

    // Starts a scan and watches it; done_at = k of edge Ek after which DONE is seen.
    task automatic run_scan(input logic [4:0] sz, input int poke_k, output int done_at, output int busy_cnt);
        int k;
        done_at  = -1;
        busy_cnt = 0;
        k        = 0;
        @(negedge CLOCK);
        SIZE  = sz;
        START = 1'b1;
        @(negedge CLOCK);
        START = 1'b0;
        checks++;
        if (FILL_COUNT !== 10'd0 || WIN !== 1'b0) begin
            failures++;
            $display("FAIL start_clear: fill=%0d win=%0b, required fill=0 win=0", FILL_COUNT, WIN);
        end
        while (k < 2000) begin
            if (k < 4) begin
                addr_r[k] = ROW;
                addr_c[k] = COL;
            end
            if (BUSY !== 1'b1) break;
            busy_cnt++;
            if (DONE === 1'b1 && done_at < 0) done_at = k;
            START = (k == poke_k);
            if (k == poke_k) SIZE = 5'd3;
            @(negedge CLOCK);
            k++;
        end
        START = 1'b0;
        checks++;
        if (k >= 2000) begin
            failures++;
            $display("FAIL scan_timeout: still busy after %0d cycles, required idle", k);
        end
    endtask

    task automatic test_board(input string name, input logic [4:0] sz, input int poke_k,
                              input int exp_done, input int exp_fill, input logic exp_win);
        int done_at;
        int busy_cnt;
        run_scan(sz, poke_k, done_at, busy_cnt);
        checks++;
        if (done_at !== exp_done) begin
            failures++;
            $display("FAIL %s done_edge: got %0d, required %0d", name, done_at, exp_done);
        end
        checks++;
        if (busy_cnt !== exp_done + 1) begin
            failures++;
            $display("FAIL %s busy_cycles: got %0d, required %0d", name, busy_cnt, exp_done + 1);
        end
        checks++;
        if (FILL_COUNT !== 10'(exp_fill)) begin
            failures++;
            $display("FAIL %s fill_count: got %0d, required %0d", name, FILL_COUNT, exp_fill);
        end
        checks++;
        if (WIN !== exp_win) begin
            failures++;
            $display("FAIL %s win: got %0b, required %0b", name, WIN, exp_win);
        end
        repeat (2) @(negedge CLOCK);
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || FILL_COUNT !== 10'(exp_fill) || WIN !== exp_win) begin
            failures++;
            $display("FAIL %s hold: busy=%0b done=%0b fill=%0d win=%0b, required 0 0 %0d %0b",
                     name, BUSY, DONE, FILL_COUNT, WIN, exp_fill, exp_win);
        end
    endtask

    task automatic test_reset();
        fill_board(3'd0);
        RESET = 1'b1;
        repeat (3) @(negedge CLOCK);
        checks++;
        if (ROW !== 5'd0 || COL !== 5'd0 || BUSY !== 1'b0 || DONE !== 1'b0 ||
            WIN !== 1'b0 || FILL_COUNT !== 10'd0 || STATE !== 2'd0) begin
            failures++;
            $display("FAIL reset_state: row=%0d col=%0d busy=%0b done=%0b win=%0b fill=%0d state=%0d, required all 0",
                     ROW, COL, BUSY, DONE, WIN, FILL_COUNT, STATE);
        end
        START = 1'b1;
        SIZE  = 5'd4;
        @(negedge CLOCK);
        START = 1'b0;
        checks++;
        if (BUSY !== 1'b0 || STATE !== 2'd0) begin
            failures++;
            $display("FAIL reset_beats_start: busy=%0b state=%0d, required busy=0 state=0", BUSY, STATE);
        end
        RESET = 1'b0;
        @(negedge CLOCK);
    endtask

    task automatic test_uniform_2x2();
        fill_board(3'd3);
        test_board("uniform_2x2", 5'd2, 4, 4, 4, 1'b1);
        checks++;
        if (addr_r[0] !== 5'd0 || addr_c[0] !== 5'd0 || addr_r[1] !== 5'd0 || addr_c[1] !== 5'd1 ||
            addr_r[2] !== 5'd1 || addr_c[2] !== 5'd0 || addr_r[3] !== 5'd1 || addr_c[3] !== 5'd1) begin
            failures++;
            $display("FAIL addr_seq_2x2: got (%0d,%0d) (%0d,%0d) (%0d,%0d) (%0d,%0d), required (0,0) (0,1) (1,0) (1,1)",
                     addr_r[0], addr_c[0], addr_r[1], addr_c[1], addr_r[2], addr_c[2], addr_r[3], addr_c[3]);
        end
    endtask

    task automatic test_uniform_26();
        fill_board(3'd6);
        test_board("uniform_26", 5'd26, -1, 676, 676, 1'b1);
    endtask

    task automatic test_last_cell();
        fill_board(3'd1);
        board[13][13] = 3'd5;
        test_board("last_cell_14", 5'd14, -1, 196, 195, 1'b0);
    endtask

    task automatic test_early_mismatch();
        fill_board(3'd0);
        board[0][3] = 3'd2;
`ifdef WIN_DETECT_EARLY_EXIT_EN
        test_board("mismatch_10", 5'd10, 2, 4, 3, 1'b0);
`else
        test_board("mismatch_10", 5'd10, 10, 100, 99, 1'b0);
`endif
    endtask

    task automatic test_clamp();
        fill_board(3'd4);
        test_board("clamp_low", 5'd0, -1, 4, 4, 1'b1);
        test_board("clamp_high", 5'd31, -1, 676, 676, 1'b1);
    endtask

    task automatic test_reset_mid_scan();
        int saw;
        fill_board(3'd0);
        @(negedge CLOCK);
        SIZE  = 5'd10;
        START = 1'b1;
        @(negedge CLOCK);
        START = 1'b0;
        for (int k = 0; k < 50; k++) begin
            START = (k == 20);
            RESET = (k == 49);
            @(negedge CLOCK);
        end
        START = 1'b0;
        checks++;
        if (ROW !== 5'd0 || COL !== 5'd0 || BUSY !== 1'b0 || DONE !== 1'b0 ||
            WIN !== 1'b0 || FILL_COUNT !== 10'd0 || STATE !== 2'd0) begin
            failures++;
            $display("FAIL reset_mid_scan: row=%0d col=%0d busy=%0b done=%0b win=%0b fill=%0d state=%0d, required all 0",
                     ROW, COL, BUSY, DONE, WIN, FILL_COUNT, STATE);
        end
        RESET = 1'b0;
        saw = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge CLOCK);
            if (DONE === 1'b1 || BUSY === 1'b1) saw++;
        end
        checks++;
        if (saw !== 0) begin
            failures++;
            $display("FAIL no_done_after_abort: busy/done seen in %0d cycles, required 0", saw);
        end
    endtask

    initial begin
        test_reset();
        test_uniform_2x2();
        test_uniform_26();
        test_last_cell();
        test_early_mismatch();
        test_clamp();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
